// File: rtl/fan_in_pe_resp_buf.sv
// fan_in_pe_resp_buf: N-way response fan-in with a small FIFO per input,
// round-robin drain and a registered single-beat-per-cycle output.
// Upstream ports cannot be stalled; a beat arriving at a full, non-popping
// FIFO is dropped and flagged in the sticky overflow_o bit of that input.
// Optional build macro FAN_IN_RESP_CONFLICT_CNT_EN enables the contention
// counter on conflict_cnt_o; otherwise that port is tied to zero.
module fan_in_pe_resp_buf #(
  parameter int N_IN       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_IN-1:0][DATA_WIDTH-1:0]      data_r_rdata_i,
  input  logic [N_IN-1:0]                      data_r_valid_i,
  input  logic [N_IN-1:0]                      data_r_opc_i,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 data_r_valid_o,
  output logic                                 data_r_opc_o,
  output logic [$clog2(N_IN)-1:0]              data_r_src_o,
  output logic [N_IN-1:0]                      overflow_o,
  output logic [15:0]                          conflict_cnt_o
);

  localparam int SRC_W = $clog2(N_IN);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                  opc;
    logic [DATA_WIDTH-1:0] rdata;
  } beat_t;

  beat_t                       mem [N_IN][FIFO_DEPTH];
  logic [N_IN-1:0][PTR_W-1:0]  rd_ptr;
  logic [N_IN-1:0][PTR_W-1:0]  wr_ptr;
  logic [N_IN-1:0][CNT_W-1:0]  count;
  logic [SRC_W-1:0]            rr;

  logic [N_IN-1:0]             fifo_empty;
  logic [N_IN-1:0]             fifo_full;
  logic [N_IN-1:0]             cand_valid;
  beat_t [N_IN-1:0]            cand_beat;
  logic                        win_found;
  logic [SRC_W-1:0]            win_idx;
  beat_t                       win_beat;
  logic [N_IN-1:0]             pop;
  logic [N_IN-1:0]             push;
  logic [N_IN-1:0]             drop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Candidate per input: buffered head first so per-input order is kept.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fifo_empty = '0;
    fifo_full  = '0;
    cand_valid = '0;
    cand_beat  = '0;
    for (int i = 0; i < N_IN; i++) begin
      fifo_empty[i] = (count[i] == '0);
      fifo_full[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
      cand_valid[i] = !fifo_empty[i] || data_r_valid_i[i];
      cand_beat[i]  = fifo_empty[i] ? beat_t'({data_r_opc_i[i], data_r_rdata_i[i]})
                                    : mem[i][rd_ptr[i]];
    end
  end

  // Round-robin arbiter: search starts one past the last winner.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= N_IN; k++) begin
      idx = (int'(rr) + k) % N_IN;
      if (!win_found && cand_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(idx);
      end
    end
    win_beat = cand_beat[win_idx];
  end

  // FIFO control: pop on FIFO-head grant, bypass on incoming grant, else push or drop.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int i = 0; i < N_IN; i++) begin
      pop[i]  = win_found && (win_idx == SRC_W'(i)) && !fifo_empty[i];
      push[i] = data_r_valid_i[i]
                && !(win_found && (win_idx == SRC_W'(i)) && fifo_empty[i])
                && (!fifo_full[i] || pop[i]);
      drop[i] = data_r_valid_i[i] && fifo_full[i] && !pop[i];
    end
  end

  // FIFO storage writes.
  // NOTE: the data array is not reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= beat_t'({data_r_opc_i[i], data_r_rdata_i[i]});
    end
  end

  // FIFO pointers and occupancy counts.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_next(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_next(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Registered output beat, round-robin pointer and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r_valid_o <= 1'b0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= 1'b0;
      data_r_src_o   <= '0;
      rr             <= SRC_W'(N_IN - 1);
      overflow_o     <= '0;
    end else begin
      data_r_valid_o <= win_found;
      if (win_found) begin
        data_r_rdata_o <= win_beat.rdata;
        data_r_opc_o   <= win_beat.opc;
        data_r_src_o   <= win_idx;
        rr             <= win_idx;
      end
      overflow_o <= overflow_o | drop;
    end
  end

`ifdef FAN_IN_RESP_CONFLICT_CNT_EN
  // Saturating count of cycles with two or more candidates.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_o <= '0;
    end else if (($countones(cand_valid) >= 2) && (conflict_cnt_o != 16'hFFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end
`else
  assign conflict_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fan_in_pe_resp_buf.sv
// Scoreboard bench for fan_in_pe_resp_buf: directed stimulus pushes
// hand-derived expected beats; a negedge monitor pops and compares.
module tb_fan_in_pe_resp_buf;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0][31:0]      rdata_i;
  logic [3:0]            valid_i;
  logic [3:0]            opc_i;
  logic [31:0]           rdata_o;
  logic                  valid_o;
  logic                  opc_o;
  logic [1:0]            src_o;
  logic [3:0]            overflow_o;
  logic [15:0]           conflict_cnt_o;

  fan_in_pe_resp_buf #(.N_IN(4), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_r_rdata_i (rdata_i),
    .data_r_valid_i (valid_i),
    .data_r_opc_i   (opc_i),
    .data_r_rdata_o (rdata_o),
    .data_r_valid_o (valid_o),
    .data_r_opc_o   (opc_o),
    .data_r_src_o   (src_o),
    .overflow_o     (overflow_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] data;
    logic        opc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Hand-derived output order for inputs 0 and 1 streaming eight cycles.
  localparam int          FAIR_SRC [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  localparam logic [31:0] FAIR_DAT [12] = '{32'h100, 32'h200, 32'h101, 32'h201,
                                            32'h102, 32'h202, 32'h103, 32'h203,
                                            32'h104, 32'h205, 32'h106, 32'h207};
  // Input 3 (opc=1) sends 1,2,3 while input 0 streams 0x50..0x53.
  localparam int          ORD_SRC [7] = '{0, 3, 0, 3, 0, 3, 0};
  localparam logic [31:0] ORD_DAT [7] = '{32'h50, 32'h1, 32'h51, 32'h2, 32'h52, 32'h3, 32'h53};
  // Inputs 1 and 2 collide for five cycles; beat 0x94 is dropped.
  localparam int          CNT_SRC [9] = '{1, 2, 1, 2, 1, 2, 1, 2, 1};
  localparam logic [31:0] CNT_DAT [9] = '{32'h80, 32'h90, 32'h81, 32'h91, 32'h82,
                                          32'h92, 32'h83, 32'h93, 32'h84};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input int src, input logic [31:0] data, input logic opc);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.opc  = opc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i = '0;
    opc_i   = '0;
    rdata_i = '0;
  endtask

  task automatic set_in(input int i, input logic [31:0] data, input logic opc);
    valid_i[i] = 1'b1;
    rdata_i[i] = data;
    opc_i[i]   = opc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for the scoreboard to empty within a cycle budget, then idle to catch extra beats.
  task automatic drain(input string name);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: got %0d beats outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got src=%0d data=0x%0h expected no beat", src_o, rdata_o);
      end else begin
        e = exp_q.pop_front();
        check("beat_src", 32'(src_o), 32'(e.src));
        check("beat_data", rdata_o, e.data);
        check("beat_opc", 32'(opc_o), 32'(e.opc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    do_reset();
    @(negedge clk);
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_opc", 32'(opc_o), 32'h0);
    check("reset_src", 32'(src_o), 32'h0);
    check("reset_overflow", 32'(overflow_o), 32'h0);
    check("reset_conflict", 32'(conflict_cnt_o), 32'h0);

    // Single beat on input 2.
    expect_beat(2, 32'hA5, 1'b1);
    tick();
    set_in(2, 32'hA5, 1'b1);
    tick();
    clear_inputs();
    tick();
    @(negedge clk);
    check("single_valid_t2", 32'(valid_o), 32'h0);
    check("single_rdata_hold", rdata_o, 32'hA5);
    drain("single");

    // Burst collision on all four inputs.
    do_reset();
    for (int i = 0; i < 4; i++) expect_beat(i, 32'(10 + i), 1'(i & 1));
    tick();
    for (int i = 0; i < 4; i++) set_in(i, 32'(10 + i), 1'(i & 1));
    tick();
    clear_inputs();
    drain("burst");

    // Ordering on input 3 against a streaming input 0.
    do_reset();
    for (int j = 0; j < 7; j++) expect_beat(ORD_SRC[j], ORD_DAT[j], 1'(ORD_SRC[j] == 3));
    for (int k = 0; k < 4; k++) begin
      tick();
      clear_inputs();
      set_in(0, 32'h50 + 32'(k), 1'b0);
      if (k < 3) set_in(3, 32'(k + 1), 1'b1);
    end
    tick();
    clear_inputs();
    drain("order");

    // Fairness and overflow: inputs 0 and 1 every cycle.
    do_reset();
    for (int j = 0; j < 12; j++) expect_beat(FAIR_SRC[j], FAIR_DAT[j], 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      set_in(0, 32'h100 + 32'(k), 1'b0);
      set_in(1, 32'h200 + 32'(k), 1'b0);
      @(negedge clk);
      check($sformatf("fair_ovf0_c%0d", k), 32'(overflow_o[0]), 32'(k >= 6));
      check($sformatf("fair_ovf1_c%0d", k), 32'(overflow_o[1]), 32'(k >= 5));
    end
    tick();
    clear_inputs();
    drain("fair");
    check("fair_overflow_final", 32'(overflow_o), 32'h3);

    // Reset mid-drain: state left from above (last winner 1), burst then rst.
    expect_beat(2, 32'h72, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) set_in(i, 32'h70 + 32'(i), 1'b0);
    tick();
    clear_inputs();
    rst = 1'b1;
    set_in(1, 32'h99, 1'b0);
    tick();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("rstmid_valid", 32'(valid_o), 32'h0);
    check("rstmid_overflow", 32'(overflow_o), 32'h0);
    repeat (10) tick();
    check("rstmid_leftover", 32'(exp_q.size()), 32'h0);
    exp_q.delete();

    // Conflict counter: inputs 1 and 2 collide for five cycles.
    do_reset();
    for (int j = 0; j < 9; j++) expect_beat(CNT_SRC[j], CNT_DAT[j], 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      set_in(1, 32'h80 + 32'(k), 1'b0);
      set_in(2, 32'h90 + 32'(k), 1'b0);
    end
    tick();
    clear_inputs();
    drain("conflict");
    check("conflict_overflow", 32'(overflow_o), 32'h4);
`ifdef FAN_IN_RESP_CONFLICT_CNT_EN
    check("conflict_cnt", 32'(conflict_cnt_o), 32'd8);
`else
    check("conflict_cnt", 32'(conflict_cnt_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
